trigger_event_sequencer: RTL and testbench

Parametrised successor of the trigger main/control pair: arms on software enable, qualifies a masked N-channel detect vector (OR, k-of-N coincidence or forced), checks event-FIFO headroom, emits a multi-word event header, then gates a fixed number of sample writes per event until the programmed event count is reached. It sits between the command-register block and the shared sample/event FIFOs of the digitizer. It replaces the hard-wired 8-channel, OR-only trigger path.

---
 rtl/trigger_event_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_trigger_event_sequencer.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/trigger_event_sequencer.sv
// Trigger sequencer: qualifies a masked detect vector, checks event-FIFO room, emits an event
// header then gates sample writes. TRIGGER_EVENT_SEQUENCER_TIMESTAMP_EN adds a latched 32-bit timestamp.
module trigger_event_sequencer #(
    parameter int CH_NUM     = 8,
    parameter int EVNUM_W    = 14,
    parameter int SPE_W      = 32,
    parameter int FIFO_CNT_W = 15,
    parameter int FIFO_DEPTH = 16384,
    parameter int CW         = $clog2(CH_NUM + 1)
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  Control_Enable,
    input  logic                  Control_Abort,
    input  logic                  Control_Force,
    input  logic [1:0]            Control_Mode,
    input  logic [CW-1:0]         Control_Coinc,
    input  logic [CH_NUM-1:0]     Control_Channel_Mask,
    input  logic [EVNUM_W-1:0]    Control_EventNum,
    input  logic [SPE_W-1:0]      Control_Sample_Per_Event,
    input  logic [CH_NUM-1:0]     TRG_Detect_Vector,
    input  logic [FIFO_CNT_W-1:0] Fifo_CountWord,
    input  logic                  Fifo_AFull,
    output logic                  Control_Trigger_Out,
    output logic                  Control_Busy_Out,
    output logic                  ACQ_RunOut,
    output logic                  ALL_FIFO_Enable,
    output logic                  Event_Write,
    output logic [17:0]           Event_Data,
    output logic [EVNUM_W-1:0]    Event_Count,
    output logic [15:0]           Lost_Count
);
`ifdef TRIGGER_EVENT_SEQUENCER_TIMESTAMP_EN
    localparam int HDR_WORDS = 4;
`else
    localparam int HDR_WORDS = 2;
`endif
    localparam int RW = ((SPE_W > FIFO_CNT_W) ? SPE_W : FIFO_CNT_W) + 2;

    typedef enum logic [2:0] {S_IDLE, S_ARMED, S_HEADER, S_CAPTURE, S_DONE} state_t;

    state_t              state_q;
    logic [CH_NUM-1:0]   det_q, pat_q, masked;
    logic                cond_d, cond_q, trig_d, room_d;
    logic [2:0]          hdr_idx_q;
    logic [SPE_W-1:0]    spe_cnt_q;
    logic [EVNUM_W-1:0]  ev_cnt_q, ev_next_d;
    logic                done_d;
    logic [15:0]         lost_q;
    logic                trig_q, wr_q, fen_q;
    logic [17:0]         data_q, word_d;
    logic [CW-1:0]       pop_d, k_eff;
    logic [RW-1:0]       cnt_x, free_x, need_x;

    assign masked = det_q & Control_Channel_Mask;

    always_comb begin
        pop_d = '0;
        for (int i = 0; i < CH_NUM; i++) pop_d = pop_d + CW'(masked[i]);
        k_eff = (Control_Coinc == '0) ? CW'(1) : Control_Coinc;
        case (Control_Mode)
            2'b01:   cond_d = (pop_d >= k_eff);
            2'b10:   cond_d = 1'b0;
            default: cond_d = |masked;
        endcase
    end

    // Rising edge of the condition only, so a held detect fires once.
    assign trig_d = (cond_d & ~cond_q) | Control_Force;

    // Occupancy above depth clamps free space to zero instead of wrapping.
    always_comb begin
        cnt_x  = RW'(Fifo_CountWord);
        free_x = (cnt_x >= RW'(FIFO_DEPTH)) ? '0 : RW'(FIFO_DEPTH) - cnt_x;
        need_x = RW'(Control_Sample_Per_Event) + RW'(HDR_WORDS);
        room_d = !Fifo_AFull && (free_x >= need_x);
    end

    assign ev_next_d = ev_cnt_q + EVNUM_W'(1);
    assign done_d    = (Control_EventNum != '0) && (ev_next_d == Control_EventNum);

`ifdef TRIGGER_EVENT_SEQUENCER_TIMESTAMP_EN
    logic [31:0] ts_q, ts_lat_q;
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) ts_q <= '0;
        else       ts_q <= ts_q + 32'd1;
    end
`endif

    always_comb begin
        case (hdr_idx_q)
            3'd1:    word_d = {2'b01, 16'(pat_q)};
`ifdef TRIGGER_EVENT_SEQUENCER_TIMESTAMP_EN
            3'd2:    word_d = {2'b00, ts_lat_q[31:16]};
            3'd3:    word_d = {2'b00, ts_lat_q[15:0]};
`endif
            default: word_d = {2'b10, 16'(ev_cnt_q)};
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q   <= S_IDLE;
            det_q     <= '0;
            cond_q    <= 1'b0;
            pat_q     <= '0;
            hdr_idx_q <= '0;
            spe_cnt_q <= '0;
            ev_cnt_q  <= '0;
            lost_q    <= '0;
            trig_q    <= 1'b0;
            wr_q      <= 1'b0;
            fen_q     <= 1'b0;
            data_q    <= '0;
`ifdef TRIGGER_EVENT_SEQUENCER_TIMESTAMP_EN
            ts_lat_q  <= '0;
`endif
        end else begin
            det_q  <= TRG_Detect_Vector;
            cond_q <= cond_d;
            trig_q <= 1'b0;
            wr_q   <= 1'b0;
            fen_q  <= 1'b0;
            if (Control_Abort) begin
                state_q <= S_IDLE;
            end else begin
                case (state_q)
                    S_IDLE: if (Control_Enable) begin
                        state_q  <= S_ARMED;
                        ev_cnt_q <= '0;
                        lost_q   <= '0;
                    end
                    S_ARMED: begin
                        if (!Control_Enable) begin
                            state_q <= S_IDLE;
                        end else if (trig_d) begin
                            if (room_d) begin
                                state_q   <= S_HEADER;
                                pat_q     <= masked;
                                trig_q    <= 1'b1;
                                wr_q      <= 1'b1;
                                data_q    <= {2'b10, 16'(ev_cnt_q)};
                                hdr_idx_q <= 3'd1;
`ifdef TRIGGER_EVENT_SEQUENCER_TIMESTAMP_EN
                                ts_lat_q  <= ts_q;
`endif
                            end else if (lost_q != 16'hFFFF) begin
                                lost_q <= lost_q + 16'd1;
                            end
                        end
                    end
                    S_HEADER: begin
                        if (hdr_idx_q == 3'(HDR_WORDS)) begin
                            if (Control_Sample_Per_Event == '0) begin
                                ev_cnt_q <= ev_next_d;
                                state_q  <= done_d ? S_DONE : S_ARMED;
                            end else begin
                                state_q   <= S_CAPTURE;
                                fen_q     <= 1'b1;
                                spe_cnt_q <= SPE_W'(1);
                            end
                        end else begin
                            wr_q      <= 1'b1;
                            data_q    <= word_d;
                            hdr_idx_q <= hdr_idx_q + 3'd1;
                        end
                    end
                    S_CAPTURE: begin
                        if (spe_cnt_q == Control_Sample_Per_Event) begin
                            ev_cnt_q <= ev_next_d;
                            state_q  <= done_d ? S_DONE : S_ARMED;
                        end else begin
                            fen_q     <= 1'b1;
                            spe_cnt_q <= spe_cnt_q + SPE_W'(1);
                        end
                    end
                    S_DONE: if (!Control_Enable) state_q <= S_IDLE;
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign Control_Busy_Out    = (state_q == S_ARMED) || (state_q == S_HEADER) || (state_q == S_CAPTURE);
    assign ACQ_RunOut          = Control_Busy_Out;
    assign Control_Trigger_Out = trig_q;
    assign Event_Write         = wr_q;
    assign Event_Data          = data_q;
    assign ALL_FIFO_Enable     = fen_q;
    assign Event_Count         = ev_cnt_q;
    assign Lost_Count          = lost_q;

endmodule

// File: tb/tb_trigger_event_sequencer.sv
// Directed bench: a per-cycle vector table for a two-event run plus hand sequences for corner cases.
module tb_trigger_event_sequencer;
    logic        Clock = 1'b0, Reset = 1'b1;
    logic        en = 0, abort = 0, frc = 0, afull = 0;
    logic [1:0]  mode = 0;
    logic [3:0]  coinc = 0;
    logic [7:0]  mask = 0, det = 0;
    logic [13:0] evnum = 0;
    logic [31:0] spe = 0;
    logic [14:0] fcnt = 0;
    logic        trig, busy, run, fen, wr;
    logic [17:0] data;
    logic [13:0] ecnt;
    logic [15:0] lost;
    int checks = 0, failures = 0;

    trigger_event_sequencer dut (
        .Clock(Clock), .Reset(Reset), .Control_Enable(en), .Control_Abort(abort),
        .Control_Force(frc), .Control_Mode(mode), .Control_Coinc(coinc),
        .Control_Channel_Mask(mask), .Control_EventNum(evnum),
        .Control_Sample_Per_Event(spe), .TRG_Detect_Vector(det),
        .Fifo_CountWord(fcnt), .Fifo_AFull(afull), .Control_Trigger_Out(trig),
        .Control_Busy_Out(busy), .ACQ_RunOut(run), .ALL_FIFO_Enable(fen),
        .Event_Write(wr), .Event_Data(data), .Event_Count(ecnt), .Lost_Count(lost));

    always #5 Clock = ~Clock;

    typedef struct {
        logic        en;
        logic [7:0]  det;
        logic        trig, wr;
        logic [17:0] data;
        logic        fen, busy;
        logic [13:0] cnt;
        logic [15:0] lost;
    } vec_t;

    vec_t tv[18];

    function automatic vec_t mk(input logic e, input logic [7:0] d, input logic t, input logic w,
                                input logic [17:0] dt, input logic f, input logic b,
                                input logic [13:0] c, input logic [15:0] l);
        vec_t v;
        v.en = e; v.det = d; v.trig = t; v.wr = w; v.data = dt;
        v.fen = f; v.busy = b; v.cnt = c; v.lost = l;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    function automatic logic [63:0] snap();
        return {11'd0, trig, wr, (wr ? data : 18'd0), fen, busy, run, ecnt, lost};
    endfunction

    initial begin
        int ntrig, nfen;
        tv[0]  = mk(1, 8'h00, 0, 0, 18'h0,     0, 1, 0, 0);
        tv[1]  = mk(1, 8'h01, 0, 0, 18'h0,     0, 1, 0, 0);
        tv[2]  = mk(1, 8'h00, 1, 1, 18'h20000, 0, 1, 0, 0);
        tv[3]  = mk(1, 8'h00, 0, 1, 18'h10001, 0, 1, 0, 0);
        for (int i = 4; i < 8; i++) tv[i] = mk(1, 8'h00, 0, 0, 18'h0, 1, 1, 0, 0);
        tv[8]  = mk(1, 8'h00, 0, 0, 18'h0,     0, 1, 1, 0);
        tv[9]  = mk(1, 8'h01, 0, 0, 18'h0,     0, 1, 1, 0);
        tv[10] = mk(1, 8'h00, 1, 1, 18'h20001, 0, 1, 1, 0);
        tv[11] = mk(1, 8'h00, 0, 1, 18'h10001, 0, 1, 1, 0);
        for (int i = 12; i < 16; i++) tv[i] = mk(1, 8'h00, 0, 0, 18'h0, 1, 1, 1, 0);
        tv[16] = mk(1, 8'h00, 0, 0, 18'h0,     0, 0, 2, 0);
        tv[17] = mk(1, 8'h00, 0, 0, 18'h0,     0, 0, 2, 0);

        #12;
        chk("reset_outputs", snap(), 64'd0);
        @(negedge Clock);
        Reset = 0;
        step();

        // Two-event OR run, vector table
        mode = 2'b00; mask = 8'h01; spe = 4; evnum = 2;
        for (int i = 0; i < 18; i++) begin
            vec_t v;
            v = tv[i];
            en = v.en; det = v.det;
            step();
            chk($sformatf("table_row%0d", i), snap(),
                {11'd0, v.trig, v.wr, v.data, v.fen, v.busy, v.busy, v.cnt, v.lost});
        end
        en = 0; step();
        chk("idle_count_held", {busy, 18'd0, ecnt}, {1'b0, 18'd0, 14'd2});

        // Coincidence k=3: 2 channels rejected, 3 accepted
        mode = 2'b01; coinc = 3; mask = 8'hFF; spe = 1; evnum = 0;
        en = 1; step();
        det = 8'h03; step();
        det = 8'h00; step();
        chk("coinc_below_k", {trig, wr}, 2'b00);
        det = 8'h07; step();
        det = 8'h00; step();
        chk("coinc_word0", {trig, wr, data}, {1'b1, 1'b1, 18'h20000});
        step();
        chk("coinc_word1", {wr, data}, {1'b1, 18'h10007});
        step();
        chk("coinc_capture", {fen, wr}, 2'b10);
        step();
        chk("coinc_done_evt", {fen, busy, 2'b00, ecnt}, {1'b0, 1'b1, 2'b00, 14'd1});
        en = 0; step();

        // FIFO room: occupancy reject, afull reject, exact-fit accept, then abort
        mode = 2'b00; mask = 8'h01; spe = 8; evnum = 0; fcnt = 15'd16380;
        en = 1; step();
        det = 8'h01; step();
        det = 8'h00; step();
        chk("room_reject", {trig, wr, busy, lost}, {1'b0, 1'b0, 1'b1, 16'd1});
        fcnt = 0; afull = 1;
        det = 8'h01; step();
        det = 8'h00; step();
        chk("afull_reject", {trig, wr, lost}, {1'b0, 1'b0, 16'd2});
        afull = 0; fcnt = 15'd16374;
        det = 8'h01; step();
        det = 8'h00; step();
        chk("room_exact_fit", {trig, wr, lost}, {1'b1, 1'b1, 16'd2});
        abort = 1; step();
        abort = 0;
        chk("abort_in_header", {busy, wr, fen, lost}, {1'b0, 1'b0, 1'b0, 16'd2});
        en = 0; fcnt = 0; step();

        // Abort on second capture cycle
        spe = 10;
        en = 1; step();
        det = 8'h01; step();
        det = 8'h00; step();
        chk("abort_word0", {trig, data}, {1'b1, 18'h20000});
        step(); step();
        chk("abort_cap1", fen, 1'b1);
        step();
        chk("abort_cap2", fen, 1'b1);
        abort = 1; step();
        abort = 0;
        chk("abort_result", {fen, busy, run, 1'b0, ecnt}, {1'b0, 1'b0, 1'b0, 1'b0, 14'd0});
        en = 0; step();

        // Force-only mode, SPE=0, single-event run
        mode = 2'b10; mask = 8'hFF; spe = 0; evnum = 1;
        en = 1; step();
        det = 8'hFF; step(); step();
        chk("force_mode_ignores_det", {trig, wr}, 2'b00);
        frc = 1; step();
        frc = 0;
        chk("force_word0", {trig, wr, data}, {1'b1, 1'b1, 18'h20000});
        step();
        chk("force_word1", {wr, data}, {1'b1, 18'h100FF});
        step();
        chk("force_spe0_done", {fen, busy, 2'b00, ecnt}, {1'b0, 1'b0, 2'b00, 14'd1});
        en = 0; step();
        en = 1; step();
        frc = 1; abort = 1; step();
        frc = 0; abort = 0;
        chk("abort_beats_force", {trig, wr, busy}, 3'b000);
        en = 0; det = 8'h00; step();

        // Held detect yields exactly one event
        mode = 2'b00; mask = 8'h01; spe = 4; evnum = 0;
        en = 1; step();
        det = 8'h01;
        ntrig = 0; nfen = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (trig) ntrig++;
            if (fen) nfen++;
        end
        chk("held_one_trigger", 64'(ntrig), 64'd1);
        chk("held_four_enables", 64'(nfen), 64'd4);
        chk("held_count", {busy, 1'b0, ecnt}, {1'b1, 1'b0, 14'd1});
        det = 0; en = 0; step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
